// File: rtl/proc_stim_checker.sv
`default_nettype none
// ============================================================================
// Module      : proc_stim_checker
// Description : On-chip stimulus generator and response checker for the
//               nibble processor core. Applies a 32-vector operand sweep
//               (phase 0: A=0..15 with B=0, phase 1: B=0..15 with A=0),
//               folds every sampled core result into a MISR signature and
//               flags pass/fail against a golden signature.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1      single clock
//   rst_n          in   1      asynchronous active-low reset
//   ena            in   1      enable; low freezes every register
//   start          in   1      one-cycle run request (honoured in IDLE/DONE)
//   stim_a         out  8      operand A to core, bits 7:4 always 0
//   stim_b         out  8      operand B to core, bits 7:4 always 0
//   dut_out        in   8      core result
//   busy           out  1      run in progress
//   done           out  1      run finished, held until next start
//   pass           out  1      valid while done: signature == EXPECTED_SIG
//   signature      out  SIG_W  live MISR value
//   vec_idx        out  5      index of applied vector, bit 4 = phase
// Optional (PROC_STIM_CAPTURE_EN defined)
//   cap_addr       in   5      capture buffer read address
//   cap_data       out  8      registered read data, one-cycle latency
//   first_fail_idx out  6      reserved, tied to zero
// Parameters
//   SETTLE_CYCLES  clocks between applying a vector and sampling (1..15)
//   SIG_W          MISR width (>= 8)
//   SIG_POLY       MISR feedback polynomial
//   SIG_SEED       MISR value loaded on start
//   EXPECTED_SIG   golden signature compared at end of run
// ============================================================================
module proc_stim_checker #(
  parameter int unsigned       SETTLE_CYCLES = 1,
  parameter int unsigned       SIG_W         = 16,
  parameter logic [SIG_W-1:0]  SIG_POLY      = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0]  SIG_SEED      = SIG_W'(16'hFFFF),
  parameter logic [SIG_W-1:0]  EXPECTED_SIG  = SIG_W'(16'h0000)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  output logic [7:0]       stim_a,
  output logic [7:0]       stim_b,
  input  logic [7:0]       dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [4:0]       vec_idx
`ifdef PROC_STIM_CAPTURE_EN
  ,
  input  logic [4:0]       cap_addr,
  output logic [7:0]       cap_data,
  output logic [5:0]       first_fail_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_settle_reload = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] c_last_vec      = 5'd31;

  state_t           r_state,   w_state_nxt;
  logic [4:0]       r_vec_idx, w_vec_idx_nxt;
  logic [3:0]       r_settle,  w_settle_nxt;
  logic [SIG_W-1:0] r_sig,     w_sig_nxt;
  logic [3:0]       r_stim_a,  w_stim_a_nxt;
  logic [3:0]       r_stim_b,  w_stim_b_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_done,    w_done_nxt;
  logic             r_pass,    w_pass_nxt;

  logic [SIG_W-1:0] w_misr;
  logic [4:0]       w_vec_inc;
  logic             w_sample;

  // Shift left, fold the MSB back through the polynomial, mix in the result.
  assign w_misr    = {r_sig[SIG_W-2:0], 1'b0}
                   ^ (r_sig[SIG_W-1] ? SIG_POLY : '0)
                   ^ SIG_W'(dut_out);
  assign w_vec_inc = r_vec_idx + 5'd1;
  // Sample on the last cycle of each hold, i.e. once the settle count is spent.
  assign w_sample  = (r_state == S_RUN) && (r_settle == 4'd0);

  always_comb begin
    w_state_nxt   = r_state;
    w_vec_idx_nxt = r_vec_idx;
    w_settle_nxt  = r_settle;
    w_sig_nxt     = r_sig;
    w_stim_a_nxt  = r_stim_a;
    w_stim_b_nxt  = r_stim_b;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_pass_nxt    = r_pass;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt   = S_RUN;
          w_vec_idx_nxt = 5'd0;
          w_stim_a_nxt  = 4'd0;
          w_stim_b_nxt  = 4'd0;
          w_sig_nxt     = SIG_SEED;
          w_settle_nxt  = c_settle_reload;
          w_busy_nxt    = 1'b1;
          w_done_nxt    = 1'b0;
          w_pass_nxt    = 1'b0;
        end
      end
      S_RUN: begin
        if (w_sample) begin
          w_sig_nxt = w_misr;
          if (r_vec_idx != c_last_vec) begin
            w_vec_idx_nxt = w_vec_inc;
            w_settle_nxt  = c_settle_reload;
            // Bit 4 of the index selects which operand sweeps.
            if (w_vec_inc[4]) begin
              w_stim_a_nxt = 4'd0;
              w_stim_b_nxt = w_vec_inc[3:0];
            end else begin
              w_stim_a_nxt = w_vec_inc[3:0];
              w_stim_b_nxt = 4'd0;
            end
          end else begin
            w_state_nxt  = S_DONE;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b1;
            w_pass_nxt   = (w_misr == EXPECTED_SIG);
            w_stim_a_nxt = 4'd0;
            w_stim_b_nxt = 4'd0;
          end
        end else begin
          w_settle_nxt = r_settle - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_vec_idx <= 5'd0;
      r_settle  <= 4'd0;
      r_sig     <= SIG_SEED;
      r_stim_a  <= 4'd0;
      r_stim_b  <= 4'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else if (ena) begin
      r_state   <= w_state_nxt;
      r_vec_idx <= w_vec_idx_nxt;
      r_settle  <= w_settle_nxt;
      r_sig     <= w_sig_nxt;
      r_stim_a  <= w_stim_a_nxt;
      r_stim_b  <= w_stim_b_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
    end
  end

  assign stim_a    = {4'd0, r_stim_a};
  assign stim_b    = {4'd0, r_stim_b};
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;
  assign vec_idx   = r_vec_idx;

`ifdef PROC_STIM_CAPTURE_EN
  // Capture memory is deliberately not reset; only entries written since the
  // last start carry meaning.
  logic [7:0] r_cap_mem [32];
  logic [7:0] r_cap_data;

  always_ff @(posedge clk) begin
    if (ena && w_sample) begin
      r_cap_mem[r_vec_idx] <= dut_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_data <= 8'd0;
    end else if (ena) begin
      r_cap_data <= r_cap_mem[cap_addr];
    end
  end

  assign cap_data       = r_cap_data;
  // Reserved for a future per-vector expected ROM; no mismatch tracking yet.
  assign first_fail_idx = 6'd0;
`endif

endmodule
`default_nettype wire
